// File: rtl/reg_file_pkg.sv
// Shared defaults and typedefs for the register file with scoreboard.
// Contents:
//   WORD_DEF / REGISTER_NUMBER_DEF / READ_PORTS_DEF / WRITE_PORTS_DEF - default sizes
//   AW_DEF                                                            - default address width
//   addr_t / word_t                                                   - default address and data types
package reg_file_pkg;

    localparam int WORD_DEF            = 32;
    localparam int REGISTER_NUMBER_DEF = 32;
    localparam int READ_PORTS_DEF      = 2;
    localparam int WRITE_PORTS_DEF     = 1;
    localparam int AW_DEF              = $clog2(REGISTER_NUMBER_DEF);

    typedef logic [AW_DEF-1:0]   addr_t;
    typedef logic [WORD_DEF-1:0] word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one busy bit per register plus a registered population count.
// Ports:
//   clk, reset_n    - clock, async active-low reset
//   issue_en_i      - reserve issue_addr_i (nonzero only)
//   issue_addr_i    - register being reserved
//   flush_i         - clear all busy bits (beats issue and write-clear)
//   wr_en_i         - per write port enable, clears the target busy bit
//   wr_addr_i       - flattened per-port write addresses
//   busy_o          - current busy vector (bit 0 always 0)
//   busy_count_o    - number of set busy bits
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int REGISTER_NUMBER = REGISTER_NUMBER_DEF,
    parameter int WRITE_PORTS     = WRITE_PORTS_DEF,
    parameter int AW              = $clog2(REGISTER_NUMBER)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        issue_en_i,
    input  logic [AW-1:0]               issue_addr_i,
    input  logic                        flush_i,
    input  logic [WRITE_PORTS-1:0]      wr_en_i,
    input  logic [WRITE_PORTS*AW-1:0]   wr_addr_i,
    output logic [REGISTER_NUMBER-1:0]  busy_o,
    output logic [AW:0]                 busy_count_o
);

    logic [REGISTER_NUMBER-1:0] busy_q, busy_d;
    logic [AW:0]                cnt_q, cnt_d;

    // Priority, lowest to highest: write-clear, issue-set, flush.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_en_i[w]) busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
        end
        if (issue_en_i) busy_d[issue_addr_i] = 1'b1;
        if (flush_i) busy_d = '0;
        busy_d[0] = 1'b0;

        // Count is taken from the next-state vector so it lines up with busy_q.
        cnt_d = '0;
        for (int i = 0; i < REGISTER_NUMBER; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = cnt_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-ported register file with write-first bypass and a pending-write scoreboard.
// Register 0 is hardwired to zero and is never busy.
// Ports:
//   clk, reset_n - clock, async active-low reset (clears data, busy bits, count)
//   wr_en        - per write port enable; highest-numbered port wins on collisions
//   wr_addr      - flattened per-port write addresses
//   wr_data      - flattened per-port write data
//   rd_addr      - flattened per-port read addresses
//   rd_data      - flattened per-port read data (combinational, write-first)
//   rd_ready     - per read port: operand not pending, or being written this cycle
//   issue_en     - reserve issue_addr as pending
//   issue_addr   - register being reserved
//   flush        - clear all pending marks at next edge
//   busy_count   - registered count of pending registers
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int WORD            = WORD_DEF,
    parameter int REGISTER_NUMBER = REGISTER_NUMBER_DEF,
    parameter int READ_PORTS      = READ_PORTS_DEF,
    parameter int WRITE_PORTS     = WRITE_PORTS_DEF,
    parameter int AW              = $clog2(REGISTER_NUMBER)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [WRITE_PORTS-1:0]        wr_en,
    input  logic [WRITE_PORTS*AW-1:0]     wr_addr,
    input  logic [WRITE_PORTS*WORD-1:0]   wr_data,
    input  logic [READ_PORTS*AW-1:0]      rd_addr,
    output logic [READ_PORTS*WORD-1:0]    rd_data,
    output logic [READ_PORTS-1:0]         rd_ready,
    input  logic                          issue_en,
    input  logic [AW-1:0]                 issue_addr,
    input  logic                          flush,
    output logic [AW:0]                   busy_count
);

    logic [WORD-1:0]            regs_q [REGISTER_NUMBER];
    logic [WORD-1:0]            regs_d [REGISTER_NUMBER];
    logic [REGISTER_NUMBER-1:0] busy;

    // Later ports overwrite earlier ones, so port WRITE_PORTS-1 wins.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_en[w]) regs_d[wr_addr[w*AW +: AW]] = wr_data[w*WORD +: WORD];
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REGISTER_NUMBER; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [WORD-1:0] data;
        logic            hit;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            hit  = 1'b0;
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                    data = wr_data[w*WORD +: WORD];
                    hit  = 1'b1;
                end
            end
        end

        // Address 0 overrides any bypass hit: it reads zero and is always ready.
        assign rd_data[p*WORD +: WORD] = (addr == '0) ? '0 : data;
        assign rd_ready[p]             = (addr == '0) | hit | ~busy[addr];
    end

    reg_scoreboard #(
        .REGISTER_NUMBER (REGISTER_NUMBER),
        .WRITE_PORTS     (WRITE_PORTS),
        .AW              (AW)
    ) u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .busy_o       (busy),
        .busy_count_o (busy_count)
    );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

    localparam int W  = 32;
    localparam int RN = 32;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WP-1:0]    wr_en = '0;
    logic [WP*AW-1:0] wr_addr = '0;
    logic [WP*W-1:0]  wr_data = '0;
    logic [RP*AW-1:0] rd_addr = '0;
    logic [RP*W-1:0]  rd_data;
    logic [RP-1:0]    rd_ready;
    logic             issue_en = 1'b0;
    logic [AW-1:0]    issue_addr = '0;
    logic             flush = 1'b0;
    logic [AW:0]      busy_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_mem  [RN];
    bit           m_busy [RN];

    reg_file_scoreboard #(
        .WORD(W), .REGISTER_NUMBER(RN), .READ_PORTS(RP), .WRITE_PORTS(WP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wa(input int w);
        return int'(wr_addr[w*AW +: AW]);
    endfunction

    function automatic int ra(input int p);
        return int'(rd_addr[p*AW +: AW]);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < RN; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Expected read: register 0 is zero; otherwise the last enabled write port
    // hitting the address supplies data, else the stored value.
    function automatic logic [W-1:0] m_rd(input int a);
        logic [W-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        for (int w = 0; w < WP; w++)
            if (wr_en[w] && wa(w) == a) v = wr_data[w*W +: W];
        return v;
    endfunction

    function automatic logic m_ready(input int a);
        if (a == 0) return 1'b1;
        for (int w = 0; w < WP; w++)
            if (wr_en[w] && wa(w) == a) return 1'b1;
        return !m_busy[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RN; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_edge();
        for (int w = 0; w < WP; w++) begin
            if (wr_en[w] && wa(w) != 0) begin
                m_mem[wa(w)]  = wr_data[w*W +: W];
                m_busy[wa(w)] = 1'b0;
            end
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        if (flush) for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
    endtask

    task automatic idle();
        wr_en = '0; issue_en = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input int port, input int a, input logic [W-1:0] d);
        wr_en[port] = 1'b1;
        wr_addr[port*AW +: AW] = AW'(a);
        wr_data[port*W +: W]   = d;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    // Called just after a falling edge with inputs set up.
    task automatic step();
        #1;
        for (int p = 0; p < RP; p++) begin
            check($sformatf("rd_data[%0d]@x%0d", p, ra(p)), 64'(rd_data[p*W +: W]), 64'(m_rd(ra(p))));
            check($sformatf("rd_ready[%0d]@x%0d", p, ra(p)), 64'(rd_ready[p]), 64'(m_ready(ra(p))));
        end
        @(posedge clk);
        m_edge();
        @(negedge clk);
        check("busy_count", 64'(busy_count), 64'(m_count()));
    endtask

    initial begin
        m_reset();
        rd(5, 5);
        #2;
        check("reset busy_count", 64'(busy_count), 64'd0);
        check("reset rd_ready", 64'(rd_ready), 64'b11);
        check("reset rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Plain write then read on both ports.
        idle(); wr(0, 5, 32'hDEADBEEF); step();
        idle(); rd(5, 5);
        #1;
        check("x5 port0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check("x5 port1", 64'(rd_data[63:32]), 64'hDEADBEEF);
        check("x5 ready", 64'(rd_ready), 64'b11);
        step();

        // Register 0 ignores writes and reservations.
        idle(); wr(0, 0, 32'h12345678); issue_en = 1'b1; issue_addr = 0; rd(0, 0);
        #1;
        check("x0 bypass", 64'(rd_data), 64'd0);
        check("x0 ready", 64'(rd_ready), 64'b11);
        step();
        idle();
        #1;
        check("x0 data", 64'(rd_data), 64'd0);
        check("x0 busy_count", 64'(busy_count), 64'd0);
        step();

        // Reservation, then satisfying write with same-cycle read.
        idle(); issue_en = 1'b1; issue_addr = 7; step();
        idle(); rd(7, 5);
        #1;
        check("x7 pending ready", 64'(rd_ready[0]), 64'd0);
        check("x7 busy_count", 64'(busy_count), 64'd1);
        step();
        idle(); wr(0, 7, 32'hA5A5A5A5); rd(7, 7);
        #1;
        check("x7 bypass data", 64'(rd_data[31:0]), 64'hA5A5A5A5);
        check("x7 bypass ready", 64'(rd_ready), 64'b11);
        step();
        check("x7 cleared count", 64'(busy_count), 64'd0);

        // Two write ports to the same register: port 1 wins.
        idle(); wr(0, 3, 32'h1111); wr(1, 3, 32'h2222); rd(3, 3);
        #1;
        check("x3 collide bypass", 64'(rd_data[31:0]), 64'h2222);
        step();
        idle();
        #1;
        check("x3 collide stored", 64'(rd_data[63:32]), 64'h2222);
        step();

        // Issue and write the same register: reservation survives.
        idle(); issue_en = 1'b1; issue_addr = 12; wr(0, 12, 32'h0C); step();
        idle(); rd(12, 12);
        #1;
        check("x12 issue+write ready", 64'(rd_ready), 64'b00);
        step();
        idle(); flush = 1'b1; step();

        // Three reservations, then flush beats issue in the same cycle.
        for (int r = 1; r <= 3; r++) begin
            idle(); issue_en = 1'b1; issue_addr = AW'(r); step();
        end
        check("three busy", 64'(busy_count), 64'd3);
        idle(); issue_en = 1'b1; issue_addr = 3; step();
        check("re-reserve count", 64'(busy_count), 64'd3);
        idle(); flush = 1'b1; issue_en = 1'b1; issue_addr = 4; wr(0, 9, 32'h55); rd(4, 9); step();
        idle();
        #1;
        check("flush x4 ready", 64'(rd_ready[0]), 64'd1);
        check("flush x9 data", 64'(rd_data[63:32]), 64'h55);
        check("flush count", 64'(busy_count), 64'd0);
        step();

        // Asynchronous reset mid-cycle, held across an edge with a write in flight.
        idle(); wr(0, 10, 32'h77); step();
        idle(); issue_en = 1'b1; issue_addr = 10; step();
        idle(); wr(0, 11, 32'h99); issue_en = 1'b1; issue_addr = 11; rd(10, 11);
        #2;
        reset_n = 1'b0;
        #1;
        check("async x10 data", 64'(rd_data[31:0]), 64'd0);
        check("async x10 ready", 64'(rd_ready[0]), 64'd1);
        check("async count", 64'(busy_count), 64'd0);
        m_reset();
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        #1;
        check("post reset x11", 64'(rd_data[63:32]), 64'd0);
        check("post reset ready", 64'(rd_ready), 64'b11);
        step();

        // Randomised traffic against the model; narrow address range forces collisions.
        for (int c = 0; c < 400; c++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
            idle();
            for (int w = 0; w < WP; w++)
                if ($urandom_range(0, 2) == 0) wr(w, $urandom_range(0, hi), $urandom);
            issue_en   = ($urandom_range(0, 1) == 1);
            issue_addr = AW'($urandom_range(0, hi));
            flush      = ($urandom_range(0, 19) == 0);
            rd($urandom_range(0, hi), $urandom_range(0, hi));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter WORD, default 32: data width in bits.
REQ-002 Parameter REGISTER_NUMBER, default 32: register count, power of two, >= 4; AW = $clog2(REGISTER_NUMBER).
REQ-003 Parameter READ_PORTS, default 2: number of independent read ports, 1..4.
REQ-004 Parameter WRITE_PORTS, default 1: number of write ports, 1..2.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  WRITE_PORTS  per-port write enable.
REQ-008 wr_addr  in  WRITE_PORTS x AW  per-port destination register.
REQ-009 wr_data  in  WRITE_PORTS x WORD  per-port write data.
REQ-010 rd_addr  in  READ_PORTS x AW  per-port source register.
REQ-011 rd_data  out  READ_PORTS x WORD  per-port read data, combinational.
REQ-012 rd_ready  out  READ_PORTS  per-port: operand holds no pending write, or is satisfied this cycle.
REQ-013 issue_en  in  1  marks issue_addr as having a pending write.
REQ-014 issue_addr  in  AW  register reserved by the issuing instruction.
REQ-015 flush  in  1  synchronous clear of all pending marks.
REQ-016 busy_count  out  AW+1  registered count of registers currently marked pending.

Function
REQ-017 Register 0 SHALL read 0 on every port, SHALL ignore writes, SHALL never be marked pending, and SHALL always report rd_ready=1.
REQ-018 A write with wr_en=1 and wr_addr!=0 SHALL update the register at the next rising edge; latency one cycle.
REQ-019 When two write ports target the same nonzero address in one cycle, port WRITE_PORTS-1 SHALL win.
REQ-020 Reads SHALL be write-first: if rd_addr matches an enabled nonzero wr_addr this cycle, rd_data SHALL be the winning wr_data, otherwise the stored value.
REQ-021 Each register SHALL hold a busy bit; issue_en=1 with issue_addr!=0 SHALL set it at the next edge.
REQ-022 An enabled write to a nonzero address SHALL clear that register's busy bit at the next edge; writes to non-busy registers SHALL be legal and leave the bit at 0.
REQ-023 Issue and write to the same register in one cycle: the busy bit SHALL end set (the new reservation supersedes).
REQ-024 rd_ready[p] SHALL be 1 when the addressed busy bit is 0 or an enabled write to that address occurs this cycle; otherwise 0.
REQ-025 flush=1 SHALL clear every busy bit at the next edge, overriding issue_en and write-clear in the same cycle; register contents SHALL still be written normally.
REQ-026 busy_count SHALL equal the population count of the busy bits after each edge, range 0..REGISTER_NUMBER-1, and SHALL never wrap.
REQ-027 A reservation of an already-busy register SHALL leave busy_count unchanged.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately clear all registers to 0, all busy bits to 0 and busy_count to 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard in-flight writes and reservations of that cycle; after release all rd_ready=1 and all rd_data=0.
REQ-030 Operation SHALL resume on the first rising edge after reset_n returns to 1.

Structure
REQ-031 Package reg_file_pkg SHALL hold default WORD/REGISTER_NUMBER/port-count constants and the address and data typedefs.
REQ-032 Busy-bit tracking, issue/clear/flush priority and busy_count SHALL be a sub-module reg_scoreboard; storage and bypass SHALL remain in reg_file_scoreboard.

Verification
REQ-033 Reset, then write x5=0xDEADBEEF; next cycle read x5 on both ports -> 0xDEADBEEF, rd_ready=11.
REQ-034 Write x0=0x12345678, issue x0 -> reads of x0 return 0, busy_count=0, rd_ready=1.
REQ-035 Issue x7; next cycle read x7 -> rd_ready=0, busy_count=1; then wr x7=0xA5A5A5A5 with same-cycle read -> rd_data=0xA5A5A5A5, rd_ready=1; next cycle busy_count=0.
REQ-036 WRITE_PORTS=2, both ports write x3 (0x1111, 0x2222) -> x3=0x2222, and a same-cycle read of x3 returns 0x2222.
REQ-037 Issue x1,x2,x3 on consecutive cycles (busy_count=3), then flush with issue x4 and wr x9=0x55 in the same cycle -> busy_count=0, x4 not busy, x9=0x55.
REQ-038 With x10 busy and holding 0x77, pulse reset_n low between edges -> immediately x10 reads 0, rd_ready=1, busy_count=0.
